// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word-addressed read or byte-lane write,
// waits LATENCY cycles, commits it to an internal word array and responds.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  counter, counter_nxt;
  logic        accept, commit, take;

  logic        cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] word_mem [DEPTH_WORDS];
  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] index;

  // Unsigned subtract: addresses below BASE_ADDR wrap high and fail the span test.
  assign offset   = cap_addr - BASE_ADDR;
  assign in_range = ({1'b0, offset} < SPAN);
  assign index    = offset[AW+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
    end
  end

  // BUSY always lasts until counter reaches 0; with LATENCY==1 the counter
  // starts at 0, so the commit lands on the edge after accept as required.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    accept      = 1'b0;
    commit      = 1'b0;
    take        = 1'b0;
    req_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept      = 1'b1;
          counter_nxt = 4'(LATENCY - 1);
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (counter == '0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end else begin
          counter_nxt = counter - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          take      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_we    <= 1'b0;
      cap_be    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_be    <= req_be;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= ~in_range;
        rsp_rdata <= (in_range && !cap_we) ? word_mem[index] : '0;
      end else if (take) begin
        rsp_valid <= 1'b0;
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (commit && cap_we && in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cap_be[i]) word_mem[index][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [3:0]  req_be    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_lat2 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_be(req_be[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_lat1 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Transaction-level model: a request occupies the responder from accept
  // until its response is taken; it commits exactly LATENCY edges after accept.
  longint      cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          m_busy  [2] = '{0, 0};
  longint      m_acc   [2];
  logic        m_we    [2];
  logic [3:0]  m_be    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic        m_rv    [2] = '{1'b0, 1'b0};
  logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
  logic        m_err   [2] = '{1'b0, 1'b0};
  logic [31:0] m_mem   [2][1024];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k]  <= 0;
        m_rv[k]    <= 1'b0;
        m_rdata[k] <= '0;
        m_err[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_busy[k] == 0) begin
          if (req_valid[k]) begin
            m_busy[k]  <= 1;
            m_acc[k]   <= cyc;
            m_we[k]    <= req_we[k];
            m_be[k]    <= req_be[k];
            m_addr[k]  <= req_addr[k];
            m_wdata[k] <= req_wdata[k];
          end
        end else if (!m_rv[k]) begin
          if (cyc == m_acc[k] + longint'(lat_of(k))) begin
            m_rv[k] <= 1'b1;
            if (m_addr[k] < 32'h0000_1000) begin
              m_err[k] <= 1'b0;
              if (m_we[k]) begin
                m_mem[k][m_addr[k][11:2]] <= lane_merge(m_mem[k][m_addr[k][11:2]], m_wdata[k], m_be[k]);
                m_rdata[k] <= '0;
              end else begin
                m_rdata[k] <= m_mem[k][m_addr[k][11:2]];
              end
            end else begin
              m_err[k]   <= 1'b1;
              m_rdata[k] <= '0;
            end
          end
        end else if (rsp_ready[k]) begin
          m_rv[k]    <= 1'b0;
          m_busy[k]  <= 0;
          m_rdata[k] <= '0;
          m_err[k]   <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d req_ready", k), 32'(req_ready[k]), 32'(m_busy[k] == 0));
      chk($sformatf("u%0d rsp_valid", k), 32'(rsp_valid[k]), 32'(m_rv[k]));
      chk($sformatf("u%0d rsp_rdata", k), rsp_rdata[k], m_rdata[k]);
      chk($sformatf("u%0d rsp_err", k), 32'(rsp_err[k]), 32'(m_err[k]));
    end
  end

  task automatic issue(input int k, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int guard = 0;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_be[k]    = be;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    while (!req_ready[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk($sformatf("u%0d accept timeout", k), 32'd1, 32'd0);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_we[k]    = ~we;
    req_be[k]    = 4'hA;
    req_addr[k]  = 32'hFFFF_FFF0;
    req_wdata[k] = 32'h5A5A_0F0F;
  endtask

  task automatic finish_rsp(input int k, input int exp_lat, input int hold,
                            output logic [31:0] rd, output logic err);
    int n = 0;
    while (!rsp_valid[k] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("u%0d latency", k), 32'(n), 32'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid[k] = 1'b1;
    end
    rd  = rsp_rdata[k];
    err = rsp_err[k];
    @(negedge clk);
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    chk($sformatf("u%0d idle after take valid", k), 32'(rsp_valid[k]), 32'd0);
    chk($sformatf("u%0d idle after take ready", k), 32'(req_ready[k]), 32'd1);
  endtask

  task automatic xfer(input int k, input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold,
                      output logic [31:0] rd, output logic err);
    issue(k, we, be, addr, wdata);
    finish_rsp(k, lat_of(k), hold, rd, err);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_be[k] = '0;
      req_addr[k]  = '0;   req_wdata[k] = '0; rsp_ready[k] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready[0]), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    #1 rst_n = 1'b1;

    xfer(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 0, rd, err);
    chk("write rdata", rd, 32'h0);
    chk("write err", 32'(err), 32'd0);

    xfer(0, 1'b1, 4'hF, 32'h20, 32'h1122_3344, 0, rd, err);
    xfer(0, 1'b1, 4'b0001, 32'h20, 32'h0000_00AA, 0, rd, err);
    xfer(0, 1'b0, 4'h0, 32'h23, 32'h0, 0, rd, err);
    chk("lane merge read", rd, 32'h1122_33AA);

    xfer(0, 1'b0, 4'h0, 32'h10, 32'h0, 5, rd, err);
    chk("backpressure read", rd, 32'hDEAD_BEEF);

    xfer(0, 1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, 0, rd, err);
    chk("be0 write err", 32'(err), 32'd0);
    xfer(0, 1'b0, 4'h0, 32'h10, 32'h0, 0, rd, err);
    chk("be0 no-op read", rd, 32'hDEAD_BEEF);

    xfer(0, 1'b1, 4'hF, 32'hFFC, 32'hCAFE_F00D, 0, rd, err);
    xfer(0, 1'b1, 4'hF, 32'h1000, 32'h0000_0099, 0, rd, err);
    chk("oob write err", 32'(err), 32'd1);
    chk("oob write rdata", rd, 32'h0);
    xfer(0, 1'b0, 4'h0, 32'hFFC, 32'h0, 0, rd, err);
    chk("last word read", rd, 32'hCAFE_F00D);
    chk("last word err", 32'(err), 32'd0);

    xfer(0, 1'b1, 4'hF, 32'h40, 32'h1234_5678, 0, rd, err);
    issue(0, 1'b1, 4'hF, 32'h40, 32'h5555_5555);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-op reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("mid-op reset req_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    xfer(0, 1'b0, 4'h0, 32'h40, 32'h0, 0, rd, err);
    chk("dropped write read", rd, 32'h1234_5678);

    xfer(1, 1'b1, 4'hF, 32'h80, 32'hA5A5_A5A5, 0, rd, err);
    xfer(1, 1'b1, 4'b1100, 32'h80, 32'h3C3C_0000, 2, rd, err);
    xfer(1, 1'b0, 4'h0, 32'h81, 32'h0, 0, rd, err);
    chk("lat1 read", rd, 32'h3C3C_A5A5);
    xfer(1, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, 0, rd, err);
    chk("lat1 oob err", 32'(err), 32'd1);
    chk("lat1 oob rdata", rd, 32'h0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
